// File: rtl/mips_hazard_ctrl_pkg.sv
// Shared definitions for the MIPS hazard/stall controller slice.
//   md_state_e : mult/div sequencer state encoding (MD_IDLE, MD_BUSY)
//   REG_W      : register-index width
//   ZERO_REG   : index of $zero, which never creates a dependency
//   reg_dep()  : true when a non-zero destination matches rs or rt
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A write to $zero is discarded by the register file, so it can never
  // be the producer in a RAW dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (dst != ZERO_REG) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline and mips_hazard_ctrl.
//   master : pipeline side, drives EX/MEM/ID status, receives stall/flush
//   slave  : controller side
// With MIPS_HAZARD_PERF_EN defined the bundle also carries the
// StallCycles / FlushCount performance counters.
interface mips_hazard_ctrl_if #(
  parameter int CNT_W = 6
);
  import mips_pkg::*;

  logic             MemReadEX;
  logic             RegWriteEX;
  logic [REG_W-1:0] WriteRegEX;
  logic             MemReadMEM;
  logic [REG_W-1:0] WriteRegMEM;
  logic [REG_W-1:0] RsID;
  logic [REG_W-1:0] RtID;
  logic             BranchID;
  logic             BranchTakenID;
  logic             JumpID;
  logic             MulDivStartEX;
  logic             MulDivUseID;
  logic             StallIF;
  logic             StallID;
  logic             FlushID;
  logic             FlushEX;
  logic             MdBusy;
  logic [CNT_W-1:0] MdCount;
`ifdef MIPS_HAZARD_PERF_EN
  logic [31:0]      StallCycles;
  logic [31:0]      FlushCount;
`endif

  modport master (
    output MemReadEX, RegWriteEX, WriteRegEX, MemReadMEM, WriteRegMEM,
           RsID, RtID, BranchID, BranchTakenID, JumpID,
           MulDivStartEX, MulDivUseID,
`ifdef MIPS_HAZARD_PERF_EN
    input  StallCycles, FlushCount,
`endif
    input  StallIF, StallID, FlushID, FlushEX, MdBusy, MdCount
  );

  modport slave (
    input  MemReadEX, RegWriteEX, WriteRegEX, MemReadMEM, WriteRegMEM,
           RsID, RtID, BranchID, BranchTakenID, JumpID,
           MulDivStartEX, MulDivUseID,
`ifdef MIPS_HAZARD_PERF_EN
    output StallCycles, FlushCount,
`endif
    output StallIF, StallID, FlushID, FlushEX, MdBusy, MdCount
  );

endinterface

// File: rtl/mips_hazard_ctrl_muldiv_seq.sv
// Multi-cycle MULT/DIV busy sequencer.
//   clk, reset    : clock, synchronous active-high reset
//   MulDivStartEX : single-cycle pulse, MULT/DIV issued from EX
//   MdBusy        : HI/LO unit occupied (MD_LATENCY cycles after the pulse)
//   MdCount       : remaining busy cycles, counts MD_LATENCY-1 down to 0
module mips_muldiv_seq
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MulDivStartEX,
  output logic             MdBusy,
  output logic [CNT_W-1:0] MdCount
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LATENCY - 1);

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] count, count_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // A start pulse while busy is ignored: the ID-stage HI/LO hazard keeps a
  // second MULT/DIV out of EX until the unit is free.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      MD_IDLE: begin
        if (MulDivStartEX) begin
          state_nx = MD_BUSY;
          count_nx = CNT_LAST;
        end
      end
      MD_BUSY: begin
        if (count != '0) count_nx = count - 1'b1;
        else             state_nx = MD_IDLE;
      end
    endcase
  end

  assign MdBusy  = (state == MD_BUSY);
  assign MdCount = count;

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core.
// Detects hazards forwarding cannot cover (load-use, ID-stage branch operand
// dependency, HI/LO access during MULT/DIV) and drives PC/IF-ID hold,
// IF-ID flush and ID-EX bubble. All stall/flush outputs are combinational.
//   clk, reset : clock, synchronous active-high reset
//   hz         : mips_hazard_ctrl_if.slave (pipeline status in, controls out)
// Optional build macro: MIPS_HAZARD_PERF_EN adds saturating StallCycles and
// FlushCount counters to the interface.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  mips_hazard_ctrl_if.slave  hz
);

  logic             md_busy;
  logic [CNT_W-1:0] md_count;
  logic             load_use;
  logic             br_haz;
  logic             md_haz;
  logic             stall;
  logic             flush_id;

  mips_muldiv_seq #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_muldiv_seq (
    .clk           (clk),
    .reset         (reset),
    .MulDivStartEX (hz.MulDivStartEX),
    .MdBusy        (md_busy),
    .MdCount       (md_count)
  );

  always_comb begin
    load_use = hz.MemReadEX && reg_dep(hz.WriteRegEX, hz.RsID, hz.RtID);
    // Branches compare in ID, so both an ALU result still in EX and a load
    // still in MEM are too late. A load in EX feeding a branch therefore
    // trips the EX term, then the MEM term the following cycle.
    br_haz   = hz.BranchID &&
               ((hz.RegWriteEX && reg_dep(hz.WriteRegEX, hz.RsID, hz.RtID)) ||
                (hz.MemReadMEM && reg_dep(hz.WriteRegMEM, hz.RsID, hz.RtID)));
    // The start cycle counts too: the MULT/DIV in EX has not yet raised busy.
    md_haz   = hz.MulDivUseID && (md_busy || hz.MulDivStartEX);
    stall    = load_use || br_haz || md_haz;
    // A stalled branch's comparison is based on stale operands; never act on it.
    flush_id = (hz.BranchTakenID || hz.JumpID) && !stall;
  end

  assign hz.StallIF = stall;
  assign hz.StallID = stall;
  assign hz.FlushEX = stall;
  assign hz.FlushID = flush_id;
  assign hz.MdBusy  = md_busy;
  assign hz.MdCount = md_count;

`ifdef MIPS_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)    stall_cycles <= sat_inc(stall_cycles);
      if (flush_id) flush_count  <= sat_inc(flush_count);
    end
  end

  assign hz.StallCycles = stall_cycles;
  assign hz.FlushCount  = flush_count;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
module tb_mips_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  mips_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int md_left;          // cycles of HI/LO occupancy still to come, 0 = free
`ifdef MIPS_HAZARD_PERF_EN
  logic [31:0] m_stalls, m_flushes;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clr_in();
    hz.MemReadEX = 0; hz.RegWriteEX = 0; hz.WriteRegEX = 0;
    hz.MemReadMEM = 0; hz.WriteRegMEM = 0; hz.RsID = 0; hz.RtID = 0;
    hz.BranchID = 0; hz.BranchTakenID = 0; hz.JumpID = 0;
    hz.MulDivStartEX = 0; hz.MulDivUseID = 0;
  endtask

  function automatic bit dep(input int d, input int s, input int t);
    return d != 0 && (d == s || d == t);
  endfunction

  // Compare every output against the reference, then advance one clock.
  task automatic step(input string tag);
    bit busy, lu, bh, mh, st, fl;
    int cnt;
    #1;
    busy = md_left > 0;
    cnt  = busy ? md_left - 1 : 0;
    lu = hz.MemReadEX && dep(hz.WriteRegEX, hz.RsID, hz.RtID);
    bh = hz.BranchID && ((hz.RegWriteEX && dep(hz.WriteRegEX, hz.RsID, hz.RtID)) ||
                         (hz.MemReadMEM && dep(hz.WriteRegMEM, hz.RsID, hz.RtID)));
    mh = hz.MulDivUseID && (busy || hz.MulDivStartEX);
    st = lu || bh || mh;
    fl = (hz.BranchTakenID || hz.JumpID) && !st;
    check({tag, ".StallIF"}, hz.StallIF, st);
    check({tag, ".StallID"}, hz.StallID, st);
    check({tag, ".FlushEX"}, hz.FlushEX, st);
    check({tag, ".FlushID"}, hz.FlushID, fl);
    check({tag, ".MdBusy"},  hz.MdBusy,  busy);
    check({tag, ".MdCount"}, hz.MdCount, cnt);
`ifdef MIPS_HAZARD_PERF_EN
    check({tag, ".StallCycles"}, hz.StallCycles, m_stalls);
    check({tag, ".FlushCount"},  hz.FlushCount,  m_flushes);
`endif
    @(posedge clk);
    if (reset) md_left = 0;
    else if (busy) md_left--;
    else if (hz.MulDivStartEX) md_left = LAT;
`ifdef MIPS_HAZARD_PERF_EN
    if (reset) begin m_stalls = 0; m_flushes = 0; end
    else begin
      if (st && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (fl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    end
`endif
    #1;
  endtask

  initial begin
    reset = 1; clr_in();
    @(posedge clk); #1;
    reset = 0; md_left = 0;
`ifdef MIPS_HAZARD_PERF_EN
    m_stalls = 0; m_flushes = 0;
`endif
    step("reset_state");

    // Load-use on rs, then independent operands
    hz.MemReadEX = 1; hz.RegWriteEX = 1; hz.WriteRegEX = 5; hz.RsID = 5;
    #1 check("lu_stall", hz.StallIF, 1'b1);
    step("load_use");
    hz.RsID = 6; hz.RtID = 6;
    step("load_nodep");

    // $zero never creates a dependency
    clr_in(); hz.MemReadEX = 1; hz.WriteRegEX = 0; hz.RsID = 0;
    #1 check("zero_lu", hz.StallIF, 1'b0);
    step("zero_load");
    clr_in(); hz.RegWriteEX = 1; hz.WriteRegEX = 0; hz.BranchID = 1; hz.RsID = 0;
    step("zero_branch");

    // Load in EX feeding a branch: 2 stall cycles, then it resolves taken
    clr_in(); hz.BranchID = 1; hz.BranchTakenID = 1; hz.RsID = 8;
    hz.MemReadEX = 1; hz.RegWriteEX = 1; hz.WriteRegEX = 8;
    #1 check("br_ex_flush", hz.FlushID, 1'b0);
    step("br_ex");
    hz.MemReadEX = 0; hz.RegWriteEX = 0; hz.WriteRegEX = 0;
    hz.MemReadMEM = 1; hz.WriteRegMEM = 8;
    #1 check("br_mem_stall", hz.StallID, 1'b1);
    step("br_mem");
    hz.MemReadMEM = 0; hz.WriteRegMEM = 0;
    #1 check("br_taken_flush", hz.FlushID, 1'b1);
    step("br_taken");

    // MULT/DIV occupancy with an HI/LO user waiting in ID
    clr_in(); hz.MulDivStartEX = 1; hz.MulDivUseID = 1;
    step("md_start");
    hz.MulDivStartEX = 0;
    for (int i = 0; i < LAT; i++) begin
      #1 check("md_count_seq", hz.MdCount, LAT - 1 - i);
      step("md_busy");
    end
    #1 check("md_release", hz.FlushEX, 1'b0);
    step("md_free");

    // Reset in the middle of a sequence aborts it
    clr_in(); hz.MulDivStartEX = 1;
    step("md_start2");
    hz.MulDivStartEX = 0;
    step("md_c3");
    #1 check("md_at2", hz.MdCount, 2);
    reset = 1;
    step("md_abort");
    reset = 0;
    #1 check("abort_busy", hz.MdBusy, 1'b0);
    step("after_abort");
    hz.MulDivStartEX = 1;
    step("md_restart");
    hz.MulDivStartEX = 0;
    for (int i = 0; i < LAT + 1; i++) step("md_full");

`ifdef MIPS_HAZARD_PERF_EN
    reset = 1; clr_in(); step("perf_rst"); reset = 0;
    hz.MemReadEX = 1; hz.WriteRegEX = 3; hz.RtID = 3;
    repeat (3) step("perf_lu");
    clr_in(); hz.JumpID = 1;
    repeat (2) step("perf_j");
    clr_in();
    #1 check("perf_stalls3", hz.StallCycles, 3);
    check("perf_flush2", hz.FlushCount, 2);
    reset = 1; step("perf_clr"); reset = 0;
    #1 check("perf_stalls0", hz.StallCycles, 0);
    check("perf_flush0", hz.FlushCount, 0);
`endif

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      hz.MemReadEX     = ($urandom_range(0, 2) == 0);
      hz.RegWriteEX    = hz.MemReadEX ? 1'b1 : 1'($urandom_range(0, 1));
      hz.WriteRegEX    = 5'($urandom_range(0, 3));
      hz.MemReadMEM    = ($urandom_range(0, 2) == 0);
      hz.WriteRegMEM   = 5'($urandom_range(0, 3));
      hz.RsID          = 5'($urandom_range(0, 3));
      hz.RtID          = 5'($urandom_range(0, 3));
      hz.BranchID      = ($urandom_range(0, 2) == 0);
      hz.BranchTakenID = hz.BranchID && ($urandom_range(0, 1) == 1);
      hz.JumpID        = ($urandom_range(0, 5) == 0);
      hz.MulDivStartEX = ($urandom_range(0, 9) == 0);
      hz.MulDivUseID   = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 59) == 0);
      step("rand");
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
Pipeline hazard/stall controller for the 5-stage MIPS core; companion to the EX-stage forwarding unit.
- Detects the hazards forwarding cannot resolve: load-use, ID-stage branch operand dependency, and HI/LO access during a multi-cycle MULT/DIV.
- Drives PC/IF-ID hold, IF-ID flush and ID-EX bubble.
- Owns the multi-cycle mult/div busy sequencer.

Parameters:
- MD_LATENCY, 32, cycles a MULT/DIV occupies the HI/LO unit after issue from EX (legal range 2..63)
- CNT_W, 6, width of the busy down-counter (must hold MD_LATENCY-1)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemReadEX  in  1  instruction in EX is a load
- RegWriteEX  in  1  instruction in EX writes the register file
- WriteRegEX  in  5  destination register of the EX instruction
- MemReadMEM  in  1  instruction in MEM is a load
- WriteRegMEM  in  5  destination register of the MEM instruction
- RsID  in  5  rs field of the ID instruction
- RtID  in  5  rt field of the ID instruction
- BranchID  in  1  ID instruction is a BEQ/BNE (compares in ID)
- BranchTakenID  in  1  ID comparator result: taken
- JumpID  in  1  ID instruction is J/JAL/JR
- MulDivStartEX  in  1  MULT/DIV(U) is in EX this cycle (single-cycle pulse)
- MulDivUseID  in  1  ID instruction uses HI/LO (MFHI/MFLO/MTHI/MTLO/MULT/DIV)
- StallIF  out  1  hold PC
- StallID  out  1  hold IF/ID register
- FlushID  out  1  clear IF/ID register (squash fetched instruction)
- FlushEX  out  1  load bubble into ID/EX (control bits zero)
- MdBusy  out  1  mult/div unit occupied
- MdCount  out  CNT_W  remaining busy cycles

Behaviour:
- Registers: state (IDLE, MD_BUSY) and MdCount. Everything else is combinational from state and inputs.
- Reset: at a clk edge with reset=1, state becomes IDLE and MdCount 0; all outputs read 0 in the following cycle. Reset during MD_BUSY aborts the sequence the same way.
- Load-use: loadUse = MemReadEX && WriteRegEX!=0 && (WriteRegEX==RsID || WriteRegEX==RtID).
- Branch dependency: brHaz = BranchID && ((RegWriteEX && WriteRegEX!=0 && WriteRegEX matches RsID or RtID) || (MemReadMEM && WriteRegMEM!=0 && WriteRegMEM matches RsID or RtID)).
  - An EX load feeding a branch stalls 2 cycles: first via the EX term, then via the MEM term.
- HI/LO hazard: mdHaz = MulDivUseID && (MdBusy || MulDivStartEX).
- stall = loadUse || brHaz || mdHaz. When stall=1: StallIF=1, StallID=1, FlushEX=1.
- Control flush: FlushID = (BranchTakenID || JumpID) && !stall.
  - A stalled branch never flushes, because its comparison is invalid.
  - FlushID and stall are never both 1.
- Sequencer, IDLE: on MulDivStartEX go to MD_BUSY with MdCount=MD_LATENCY-1. MdBusy=0.
- Sequencer, MD_BUSY: MdBusy=1.
  - If MdCount!=0, MdCount decrements.
  - If MdCount==0, go to IDLE.
  - MdBusy is therefore high for exactly MD_LATENCY cycles starting the cycle after the start pulse.
- MulDivStartEX while MD_BUSY is ignored (no restart). This is unreachable in a correct pipeline because mdHaz stalls the second MULT/DIV in ID.
- Register 0 never causes a hazard.
- Latency: all stall/flush outputs are zero-latency (same cycle as the triggering inputs).

Optional Feature:
- Macro: MIPS_HAZARD_PERF_EN.
- When defined, adds two outputs:
  - StallCycles (32-bit): increments every cycle stall=1.
  - FlushCount (32-bit): increments every cycle FlushID=1.
  - Both clear on reset and saturate at 0xFFFFFFFF.
- When undefined, these ports and registers do not exist and the block is otherwise identical.

Decomposition:
- Shared package mips_pkg: state encoding (MD_IDLE=1'b0, MD_BUSY=1'b1), register-index width constant REG_W=5, and ZERO_REG=5'd0.
- One natural sub-module, mips_muldiv_seq: the IDLE/MD_BUSY FSM plus MdCount. Inputs clk, reset, MulDivStartEX; outputs MdBusy, MdCount.
- Hazard equations stay in the top module.

Test Plan:
- LW $5 in EX (MemReadEX=1, WriteRegEX=5), RsID=5 → StallIF=StallID=FlushEX=1 for 1 cycle; with RsID=RtID=6 → all 0.
- WriteRegEX=0 with MemReadEX=1 and RsID=0 → no stall. Separately, RegWriteEX=1, WriteRegEX=0, BranchID=1, RsID=0 → no stall.
- BranchID=1, RsID=8, MemReadEX=1, WriteRegEX=8, next cycle MemReadMEM=1, WriteRegMEM=8 → stall 2 cycles, FlushID=0 throughout; then BranchTakenID=1 → FlushID=1 for 1 cycle.
- MulDivStartEX pulse with MD_LATENCY=4 → MdBusy high 4 cycles, MdCount 3,2,1,0. MulDivUseID=1 held → stall during the start cycle plus those 4 cycles, released the cycle MdBusy=0.
- reset=1 asserted when MdCount=2 → next cycle MdBusy=0, MdCount=0, all outputs 0; a new start then runs the full 4 cycles.
- With MIPS_HAZARD_PERF_EN: 3 load-use stalls plus 2 jumps → StallCycles=3, FlushCount=2; reset clears both.
